prvp_dc_token_reader: RTL and testbench

Read-side controller of a dual-clock token-ring buffer in the C2C peripheral. The write domain stores data into slot i and toggles wr_flag[i]. This block synchronizes those flags into the read clock domain and walks its own one-hot read token around the slots. It presents slot data through a registered valid/ready port and returns rd_flag[i] to the writer to free the slot.

---
 rtl/prvp_dc_pkg.sv | 41 ++++
 rtl/prvp_dc_sync_bit.sv | 23 ++
 rtl/prvp_dc_token_reader.sv | 75 +++++++
 tb/tb_prvp_dc_token_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/prvp_dc_pkg.sv
// Shared constants and helper functions for the dual-clock token-ring reader.
// Helpers work on MAX-sized vectors; callers zero-extend inputs and size-cast results.
package prvp_dc_pkg;

  localparam int unsigned MAX_DEPTH = 32;
  localparam int unsigned MAX_WIDTH = 64;

  localparam logic [MAX_DEPTH-1:0] RD_TOKEN_RESET = 'h1;

  function automatic logic [7:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

  // Rotate the low n bits of v left by one; bits at or above n are cleared.
  function automatic logic [MAX_DEPTH-1:0] rotl(input logic [MAX_DEPTH-1:0] v,
                                                 input int unsigned          n);
    logic [MAX_DEPTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

  // AND-OR select of MAX_WIDTH-strided slices by a one-hot select vector.
  function automatic logic [MAX_WIDTH-1:0] onehot_mux(input logic [MAX_DEPTH*MAX_WIDTH-1:0] data,
                                                      input logic [MAX_DEPTH-1:0]           sel);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      r = r | (data[i*MAX_WIDTH +: MAX_WIDTH] & {MAX_WIDTH{sel[i]}});
    end
    return r;
  endfunction

endpackage

// File: rtl/prvp_dc_sync_bit.sv
// Multi-stage single-bit synchronizer with asynchronous active-low reset to 0.
module prvp_dc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/prvp_dc_token_reader.sv
// Read-side controller of the dual-clock token-ring buffer: syncs writer flags,
// walks a one-hot read token and presents slot data on a registered valid/ready port.
module prvp_dc_token_reader
  import prvp_dc_pkg::*;
#(
  parameter int BUFFER_DEPTH = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int COUNT_WIDTH  = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [BUFFER_DEPTH-1:0]            wr_flag_async,
  input  logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer_data,
  output logic [BUFFER_DEPTH-1:0]            rd_flag,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic [BUFFER_DEPTH-1:0]            rd_token,
  output logic [COUNT_WIDTH-1:0]             rd_count
);

  logic [BUFFER_DEPTH-1:0]         wr_flag_sync;
  logic [BUFFER_DEPTH-1:0]         full_vec;
  logic [MAX_DEPTH*MAX_WIDTH-1:0]  slot_padded;
  logic [DATA_WIDTH-1:0]           cur_data;
  logic                            cur_full;
  logic                            pop;

  for (genvar g = 0; g < BUFFER_DEPTH; g++) begin : g_sync
    prvp_dc_sync_bit #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rstn(rstn),
      .d   (wr_flag_async[g]),
      .q   (wr_flag_sync[g])
    );
  end

  assign full_vec = wr_flag_sync ^ rd_flag;
  assign cur_full = |(full_vec & rd_token);
  assign pop      = cur_full & (~rd_valid | rd_ready);

  // Re-stride slots onto the package's fixed slice pitch so the mux helper stays generic.
  always_comb begin
    slot_padded = '0;
    for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
      slot_padded[i*MAX_WIDTH +: DATA_WIDTH] = buffer_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign cur_data = DATA_WIDTH'(onehot_mux(slot_padded, MAX_DEPTH'(rd_token)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_count <= '0;
      rd_flag  <= '0;
      rd_token <= BUFFER_DEPTH'(RD_TOKEN_RESET);
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_count <= COUNT_WIDTH'(popcount(MAX_DEPTH'(full_vec)));
      if (pop) begin
        rd_data  <= cur_data;
        rd_valid <= 1'b1;
        rd_flag  <= rd_flag ^ rd_token;
        rd_token <= BUFFER_DEPTH'(rotl(MAX_DEPTH'(rd_token), BUFFER_DEPTH));
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prvp_dc_token_reader.sv
// Scoreboard bench for prvp_dc_token_reader: a behavioural writer pushes expected
// words as it toggles flags; a monitor pops and compares on every accepted beat.
module tb_prvp_dc_token_reader;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rstn;
  logic [DEPTH-1:0]      wr_flag_async;
  logic [DEPTH*DW-1:0]   buffer_data;
  logic [DEPTH-1:0]      rd_flag;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DW-1:0]         rd_data;
  logic [DEPTH-1:0]      rd_token;
  logic [CW-1:0]         rd_count;

  prvp_dc_token_reader #(
    .BUFFER_DEPTH(DEPTH),
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_flag_async(wr_flag_async),
    .buffer_data  (buffer_data),
    .rd_flag      (rd_flag),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_token     (rd_token),
    .rd_count     (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  logic [DW-1:0] exp_q[$];
  int unsigned  beats = 0;
  int unsigned  peak  = 0;
  int unsigned  wp    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: an accepted beat is rd_valid & rd_ready seen at the negedge before the edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (int'(rd_count) > peak) peak = int'(rd_count);
      if (rd_valid && rd_ready) begin
        beats++;
        if (exp_q.size() == 0) check_eq("spurious_beat", 64'(rd_data), 64'hDEAD);
        else                   check_eq("beat_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // Writer: load n consecutive slots then toggle all their flags in one step.
  task automatic write_burst(input int unsigned n, input logic [DW-1:0] base);
    logic [DEPTH-1:0] tog;
    tog = '0;
    for (int unsigned k = 0; k < n; k++) begin
      if (wr_flag_async[wp] != rd_flag[wp]) check_eq("writer_slot_free", 64'(wp), 64'hFF);
      buffer_data[wp*DW +: DW] = base + DW'(k);
      exp_q.push_back(base + DW'(k));
      tog[wp] = 1'b1;
      wp = (wp + 1) % DEPTH;
    end
    wr_flag_async = wr_flag_async ^ tog;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (rd_valid) seen = 1;
    end
    if (!seen) check_eq("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !rd_valid) done = 1;
    end
    if (!done) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int unsigned b0;
    rstn          = 1'b0;
    rd_ready      = 1'b0;
    wr_flag_async = '0;
    buffer_data   = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_token", 64'(rd_token), 64'h01);
    check_eq("rst_flag",  64'(rd_flag),  64'h00);
    check_eq("rst_count", 64'(rd_count), 64'd0);
    check_eq("rst_data",  64'(rd_data),  64'd0);

    // Full lap: all 8 flags toggle together, drain at full rate.
    rd_ready = 1'b1;
    peak = 0;
    b0 = beats;
    write_burst(8, 32'hC0DE_0000);
    wait_drain();
    check_eq("fill_beats", 64'(beats - b0), 64'd8);
    check_eq("fill_peak",  64'(peak), 64'd8);
    check_eq("fill_token", 64'(rd_token), 64'h01);
    check_eq("fill_flag",  64'(rd_flag),  64'hFF);
    check_eq("fill_count", 64'(rd_count), 64'd0);

    // Second lap on slot 0 with exact latency.
    rd_ready = 1'b0;
    @(posedge clk); #1;
    write_burst(1, 32'hA5A5_0001);
    check_eq("lap2_wrflag", 64'(wr_flag_async), 64'hFE);
    repeat (2) @(posedge clk); #1;
    check_eq("lat_not_yet", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_valid", 64'(rd_valid), 64'd1);
    check_eq("lat_count", 64'(rd_count), 64'd1);
    check_eq("lat_data",  64'(rd_data),  64'hA5A5_0001);
    check_eq("lat_flag",  64'(rd_flag),  64'hFE);
    check_eq("lat_token", 64'(rd_token), 64'h02);
    rd_ready = 1'b1;
    wait_drain();

    // Back-pressure: 4 slots full, consumer stalled for 5 cycles.
    rd_ready = 1'b0;
    write_burst(4, 32'hBEEF_0010);
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_eq("bp_valid", 64'(rd_valid), 64'd1);
      check_eq("bp_data",  64'(rd_data),  64'hBEEF_0010);
      check_eq("bp_token", 64'(rd_token), 64'h04);
      check_eq("bp_flag",  64'(rd_flag),  64'hFC);
    end
    b0 = beats;
    rd_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_eq("bp_b2b_beats", 64'(beats - b0), 64'd4);
    check_eq("bp_drained",   64'(rd_valid), 64'd0);
    check_eq("bp_token_end", 64'(rd_token), 64'h20);

    // Reset in the middle of a pending burst.
    rd_ready = 1'b0;
    write_burst(3, 32'h7777_0100);
    wait_valid();
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check_eq("mrst_valid", 64'(rd_valid), 64'd0);
    check_eq("mrst_token", 64'(rd_token), 64'h01);
    check_eq("mrst_flag",  64'(rd_flag),  64'h00);
    check_eq("mrst_count", 64'(rd_count), 64'd0);
    check_eq("mrst_data",  64'(rd_data),  64'd0);
    wr_flag_async = '0;
    wp = 0;
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    rstn     = 1'b1;
    rd_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check_eq("post_rst_valid", 64'(rd_valid), 64'd0);
    check_eq("post_rst_count", 64'(rd_count), 64'd0);

    // Normal operation resumes after reset.
    write_burst(2, 32'h1234_5670);
    wait_drain();
    check_eq("resume_token", 64'(rd_token), 64'h04);
    check_eq("resume_flag",  64'(rd_flag),  64'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
